m_lsu: RTL and testbench
========================

# m_lsu

Parametrised memory-stage load/store unit for the pipelined MIPS core. It replaces the purely combinational load-data extender with a sequential unit. The unit accepts one load or store per transaction from the M stage and drives a variable-latency data memory through a request/ready handshake. It generates byte enables and lane-shifted store data, sign- or zero-extends load data, and holds `busy` so the hazard unit can freeze the pipeline until the response returns.

## Interface
Parameters:
- `DATA_W`, default 32: memory data width in bits. Legal values are 32 and 64.
- `ADDR_W`, default 32: byte address width.

Ports:
- `clk`  in  1  Single clock. All sequential logic updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `req_valid`  in  1  Transaction request from the M stage. Sampled only while `busy`=0.
- `req_we`  in  1  Transaction type: 1 = store, 0 = load.
- `req_size`  in  2  Access size: 0 byte, 1 half, 2 word, 3 dword. A size wider than DATA_W is clamped to the full width.
- `req_unsigned`  in  1  Load extension: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  Byte address.
- `req_wdata`  in  DATA_W  Store data, right-aligned.
- `mem_req`  out  1  Memory request. Held high until the memory accepts it.
- `mem_we`  out  1  Memory write enable.
- `mem_addr`  out  ADDR_W  Address aligned to DATA_W/8 (low offset bits forced to 0).
- `mem_be`  out  DATA_W/8  Byte enables.
- `mem_wdata`  out  DATA_W  Store data shifted into its byte lanes.
- `mem_ready`  in  1  Memory acceptance and completion, sampled while `mem_req` is high.
- `mem_rdata`  in  DATA_W  Full-width read data. Valid in the cycle `mem_ready` is high.
- `busy`  out  1  High from the cycle after acceptance until the response cycle, inclusive.
- `resp_valid`  out  1  One-cycle completion pulse.
- `resp_rdata`  out  DATA_W  Extended load data. 0 for stores and exceptions.
- `resp_exc`  out  1  Misaligned-access flag, qualified by `resp_valid`.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACCESS: `mem_req` is high.
  - RESP: one cycle with `resp_valid` high.
  - Transitions: IDLE→ACCESS on `req_valid`. ACCESS→RESP on `mem_ready`. RESP→IDLE unconditionally.
- On acceptance, latch all `req_*` signals. Compute the offset as `off = req_addr[log2(DATA_W/8)-1:0]` and the byte count as `n = 1<<size_clamped`.
- Byte enables: `mem_be` has n contiguous ones starting at bit `off`.
- Store data: `mem_wdata = req_wdata << (8*off)`. Bytes outside the enabled lanes are don't-care but driven as 0.
- Load data:
  - Select bytes [off, off+n) of `mem_rdata` and right-align them.
  - If `req_unsigned`=0, fill the upper bits with the top bit of the selected field. Otherwise fill with 0.
  - A full-width load passes `mem_rdata` through unchanged.
  - Capture the result into the `resp_rdata` register on the `mem_ready` edge.
- `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stay stable for the whole ACCESS state.
- `req_valid` while `busy`=1 is ignored. The pipeline holds its request until `busy` falls.
- Reset: the FSM returns to IDLE and every output goes to 0, immediately and asynchronously. This includes a reset mid-ACCESS, where `mem_req` drops without waiting for `mem_ready`.

## Timing
- Call the acceptance edge E0.
- `mem_req` rises after E0.
- If `mem_ready` is sampled high at edge Ek (k≥1), `resp_valid` and the response data are high for the single cycle after Ek.
- Minimum load/store latency is 2 cycles from acceptance to `resp_valid`.
- `busy` is high for ACCESS plus RESP. It is low in IDLE, so a new request can be accepted in the cycle after RESP.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - An access is misaligned when `off` is not a multiple of n.
  - A misaligned request skips ACCESS: the FSM goes IDLE→RESP, no `mem_req` is issued, and `resp_valid`=1 with `resp_exc`=1 and `resp_rdata`=0 in the cycle after E0.
- Macro undefined:
  - `resp_exc` is tied to 0.
  - Offset bits below the access size are forced to 0 before lane computation, so a misaligned address rounds down to the natural boundary.

## Test plan
- DATA_W=32, load byte, addr 0x03, `mem_rdata`=0x80FF7F01, signed: `mem_be`=4'b1000, `mem_addr`=0x00, `resp_rdata`=0xFFFFFF80. The same access with unsigned gives 0x00000080.
- DATA_W=32, store half 0xBEEF at addr 0x12: `mem_addr`=0x10, `mem_be`=4'b1100, `mem_wdata`=0xBEEF0000, `resp_rdata`=0.
- `mem_ready` held low for 5 cycles after `mem_req`: `busy` stays high, the memory outputs stay stable, and `resp_valid` pulses exactly once, one cycle after `mem_ready`.
- DATA_W=64, load word, addr 0x0C, `mem_rdata`=0x89ABCDEF_01234567, signed: `mem_be`=8'hF0, `resp_rdata`=0xFFFFFFFF_89ABCDEF.
- Load word at addr 0x02:
  - With `LSU_ALIGN_CHECK_EN`: no `mem_req`, `resp_exc`=1 one cycle after acceptance.
  - Without it: `mem_be`=4'hF and the full word is returned.
- Assert `reset` two cycles into ACCESS: `mem_req`, `busy` and `resp_valid` drop to 0 at once, and the next request is handled normally.

Source files
------------

// File: rtl/m_lsu.sv
`default_nettype none
// ============================================================================
// Module      : m_lsu
// Description : Memory-stage load/store unit. Accepts one load or store per
//               transaction, drives a variable-latency data memory through a
//               req/ready handshake, generates byte enables and lane-shifted
//               store data, and sign/zero-extends load data. 'busy' freezes
//               the pipeline from acceptance until the response cycle.
// Ports       : clk, reset (async, active high)
//               req_*  : transaction from the M stage (sampled while !busy)
//               mem_*  : data memory handshake, registered request fields
//               busy, resp_valid, resp_rdata, resp_exc : response side
// Config      : LSU_ALIGN_CHECK_EN - when defined, misaligned accesses skip
//               the memory and respond with resp_exc=1; when undefined the
//               offset is rounded down to the natural boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module m_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_exc
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [1:0] c_MAX_SIZE = 2'(OFF_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } t_state;

    t_state r_state;
    t_state w_nextState;

    // Expand a byte-lane mask into a bit mask
    function automatic logic [DATA_W-1:0] f_laneMask(input logic [BYTES-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // ---------------- request decode ----------------
    logic [1:0]        w_sizeClamped;
    logic [OFF_W:0]    w_reqBytes;
    logic [OFF_W-1:0]  w_lowMask;
    logic [OFF_W-1:0]  w_reqOff;
    logic [BYTES-1:0]  w_reqField;
    logic [BYTES-1:0]  w_reqBe;
    logic [DATA_W-1:0] w_reqWdata;
    logic              w_accept;

    assign w_sizeClamped = (req_size > c_MAX_SIZE) ? c_MAX_SIZE : req_size;
    assign w_reqBytes    = {{OFF_W{1'b0}}, 1'b1} << w_sizeClamped;
    // Offset bits that must be zero for a naturally aligned access
    assign w_lowMask     = ~({OFF_W{1'b1}} << w_sizeClamped);

`ifdef LSU_ALIGN_CHECK_EN
    logic w_misaligned;
    assign w_misaligned  = |(req_addr[OFF_W-1:0] & w_lowMask);
    assign w_reqOff      = req_addr[OFF_W-1:0];
`else
    // Round a misaligned address down to its natural boundary
    assign w_reqOff      = req_addr[OFF_W-1:0] & ~w_lowMask;
`endif

    // n contiguous ones starting at bit 0; n == BYTES shifts everything out
    assign w_reqField = ~({BYTES{1'b1}} << w_reqBytes);
    assign w_reqBe    = w_reqField << w_reqOff;
    assign w_reqWdata = (req_wdata << {w_reqOff, 3'b000}) & f_laneMask(w_reqBe);
    assign w_accept   = (r_state == S_IDLE) && req_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
                    w_nextState = w_misaligned ? S_RESP : S_ACCESS;
`else
                    w_nextState = S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // ---------------- latched transaction ----------------
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [BYTES-1:0]  r_memBe;
    logic [DATA_W-1:0] r_memWdata;
    logic [OFF_W-1:0]  r_off;
    logic [BYTES-1:0]  r_field;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_respRdata;

    // ---------------- load extraction ----------------
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_fieldMask;
    logic              w_signBit;
    logic [DATA_W-1:0] w_loadData;

    assign w_shifted   = mem_rdata >> {r_off, 3'b000};
    assign w_fieldMask = f_laneMask(r_field);
    // Top bit of the selected field: the only mask bit whose upper neighbour is clear
    assign w_signBit   = |(w_shifted & w_fieldMask & ~(w_fieldMask >> 1));
    assign w_loadData  = (w_shifted & w_fieldMask) |
                         ((!r_unsigned && w_signBit) ? ~w_fieldMask : '0);

`ifdef LSU_ALIGN_CHECK_EN
    logic r_respExc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memBe     <= '0;
            r_memWdata  <= '0;
            r_off       <= '0;
            r_field     <= '0;
            r_unsigned  <= 1'b0;
            r_respRdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            r_respExc   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_memWe     <= req_we;
            r_memAddr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_memBe     <= w_reqBe;
            r_memWdata  <= w_reqWdata;
            r_off       <= w_reqOff;
            r_field     <= w_reqField;
            r_unsigned  <= req_unsigned;
            // Cleared here so exception responses report zero data
            r_respRdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            r_respExc   <= w_misaligned;
`endif
        end else if ((r_state == S_ACCESS) && mem_ready) begin
            r_respRdata <= r_memWe ? '0 : w_loadData;
        end
    end

    // ---------------- outputs ----------------
    assign mem_req    = (r_state == S_ACCESS);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign mem_we     = r_memWe;
    assign mem_addr   = r_memAddr;
    assign mem_be     = r_memBe;
    assign mem_wdata  = r_memWdata;
    assign resp_rdata = r_respRdata;
`ifdef LSU_ALIGN_CHECK_EN
    assign resp_exc   = r_respExc;
`else
    assign resp_exc   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_lsu
// Description : Directed self-checking bench for m_lsu (32-bit and 64-bit
//               instances sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_lsu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        reqValid, reqWe, reqUnsigned, memReady;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata, memRdata;
    logic        memReq, memWe, busy, respValid, respExc;
    logic [31:0] memAddr, memWdata, respRdata;
    logic [3:0]  memBe;

    // 64-bit instance
    logic        reqValid64, reqWe64, reqUnsigned64, memReady64;
    logic [1:0]  reqSize64;
    logic [31:0] reqAddr64;
    logic [63:0] reqWdata64, memRdata64;
    logic        memReq64, memWe64, busy64, respValid64, respExc64;
    logic [31:0] memAddr64;
    logic [63:0] memWdata64, respRdata64;
    logic [7:0]  memBe64;

    m_lsu #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_we(reqWe), .req_size(reqSize),
        .req_unsigned(reqUnsigned), .req_addr(reqAddr), .req_wdata(reqWdata),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_be(memBe),
        .mem_wdata(memWdata), .mem_ready(memReady), .mem_rdata(memRdata),
        .busy(busy), .resp_valid(respValid), .resp_rdata(respRdata),
        .resp_exc(respExc)
    );

    m_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid64), .req_we(reqWe64), .req_size(reqSize64),
        .req_unsigned(reqUnsigned64), .req_addr(reqAddr64), .req_wdata(reqWdata64),
        .mem_req(memReq64), .mem_we(memWe64), .mem_addr(memAddr64), .mem_be(memBe64),
        .mem_wdata(memWdata64), .mem_ready(memReady64), .mem_rdata(memRdata64),
        .busy(busy64), .resp_valid(respValid64), .resp_rdata(respRdata64),
        .resp_exc(respExc64)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request on the 32-bit unit; returns #1 after the acceptance edge
    task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        reqValid = 1'b1; reqWe = we; reqSize = size; reqUnsigned = uns;
        reqAddr = addr; reqWdata = wdata;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    // One-cycle mem_ready; returns #1 after the edge that samples it (RESP cycle)
    task automatic ready32(input logic [31:0] rdata);
        @(negedge clk);
        memReady = 1'b1; memRdata = rdata;
        @(posedge clk); #1;
        memReady = 1'b0; memRdata = '0;
    endtask

    initial begin
        reqValid = 0; reqWe = 0; reqSize = 0; reqUnsigned = 0;
        reqAddr = '0; reqWdata = '0; memReady = 0; memRdata = '0;
        reqValid64 = 0; reqWe64 = 0; reqSize64 = 0; reqUnsigned64 = 0;
        reqAddr64 = '0; reqWdata64 = '0; memReady64 = 0; memRdata64 = '0;

        // ---- reset state ----
        #1;
        chk("rst_memReq", memReq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_respValid", respValid, 0);
        chk("rst_memBe", memBe, 0);
        chk("rst_respRdata", respRdata, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ---- load byte signed at 0x03 ----
        issue32(1'b0, 2'd0, 1'b0, 32'h03, 32'h0);
        chk("lb_memReq", memReq, 1);
        chk("lb_busy", busy, 1);
        chk("lb_memWe", memWe, 0);
        chk("lb_memBe", memBe, 4'b1000);
        chk("lb_memAddr", memAddr, 32'h0);
        ready32(32'h80FF7F01);
        chk("lb_respValid", respValid, 1);
        chk("lb_respRdata", respRdata, 32'hFFFFFF80);
        chk("lb_memReqDrop", memReq, 0);
        chk("lb_busyResp", busy, 1);
        @(posedge clk); #1;
        chk("lb_idleValid", respValid, 0);
        chk("lb_idleBusy", busy, 0);

        // ---- load byte unsigned at 0x03 ----
        issue32(1'b0, 2'd0, 1'b1, 32'h03, 32'h0);
        ready32(32'h80FF7F01);
        chk("lbu_respRdata", respRdata, 32'h00000080);
        @(posedge clk); #1;

        // ---- mem_ready in IDLE is ignored ----
        @(negedge clk); memReady = 1'b1;
        @(posedge clk); #1; memReady = 1'b0;
        chk("idleReady_respValid", respValid, 0);
        chk("idleReady_busy", busy, 0);

        // ---- store half 0xBEEF at 0x12, ready held off 5 cycles ----
        issue32(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
        chk("sh_memWe", memWe, 1);
        chk("sh_memAddr", memAddr, 32'h10);
        chk("sh_memBe", memBe, 4'b1100);
        chk("sh_memWdata", memWdata, 32'hBEEF0000);
        // A competing request while busy must not disturb the access
        reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd2; reqAddr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("sh_waitMemReq", memReq, 1);
            chk("sh_waitBusy", busy, 1);
            chk("sh_waitRespValid", respValid, 0);
            chk("sh_waitStable", {memWe, memBe, memAddr, memWdata[26:0]},
                {1'b1, 4'b1100, 32'h10, 27'h6EF0000});
        end
        reqValid = 1'b0;
        ready32(32'hFFFFFFFF);
        chk("sh_respValid", respValid, 1);
        chk("sh_respRdata", respRdata, 32'h0);
        begin
            int pulses = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (respValid) pulses++;
            end
            chk("sh_extraPulses", pulses, 0);
        end

        // ---- dword on 32-bit clamps to full width ----
        issue32(1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        chk("ld_clamp_memBe", memBe, 4'hF);
        chk("ld_clamp_memAddr", memAddr, 32'h04);
        ready32(32'h80000001);
        chk("ld_clamp_respRdata", respRdata, 32'h80000001);
        @(posedge clk); #1;

        // ---- 64-bit: load word signed at 0x0C ----
        @(negedge clk);
        reqValid64 = 1'b1; reqWe64 = 1'b0; reqSize64 = 2'd2; reqUnsigned64 = 1'b0;
        reqAddr64 = 32'h0C;
        @(posedge clk); #1; reqValid64 = 1'b0;
        chk("lw64_memReq", memReq64, 1);
        chk("lw64_memBe", memBe64, 8'hF0);
        chk("lw64_memAddr", memAddr64, 32'h08);
        @(negedge clk); memReady64 = 1'b1; memRdata64 = 64'h89ABCDEF_01234567;
        @(posedge clk); #1; memReady64 = 1'b0;
        chk("lw64_respValid", respValid64, 1);
        chk("lw64_respRdata", respRdata64, 64'hFFFFFFFF_89ABCDEF);
        @(posedge clk); #1;

        // ---- load word at misaligned 0x02 ----
        issue32(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_memReq", memReq, 0);
        chk("mis_respValid", respValid, 1);
        chk("mis_respExc", respExc, 1);
        chk("mis_respRdata", respRdata, 32'h0);
        @(posedge clk); #1;
        chk("mis_idle", busy, 0);
`else
        chk("mis_memBe", memBe, 4'hF);
        chk("mis_memAddr", memAddr, 32'h0);
        ready32(32'hDEADBEEF);
        chk("mis_respValid", respValid, 1);
        chk("mis_respRdata", respRdata, 32'hDEADBEEF);
        chk("mis_respExc", respExc, 0);
        @(posedge clk); #1;
`endif

        // ---- reset two cycles into ACCESS ----
        issue32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rstMid_memReq", memReq, 0);
        chk("rstMid_busy", busy, 0);
        chk("rstMid_respValid", respValid, 0);
        chk("rstMid_memBe", memBe, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---- normal request after reset: load half unsigned at 0x02 ----
        issue32(1'b0, 2'd1, 1'b1, 32'h02, 32'h0);
        chk("post_memReq", memReq, 1);
        chk("post_memBe", memBe, 4'b1100);
        ready32(32'h92345678);
        chk("post_respValid", respValid, 1);
        chk("post_respRdata", respRdata, 32'h00009234);
        @(posedge clk); #1;
        chk("post_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
